// File: rtl/color_classifier_stable_pkg.sv
// Shared definitions for the stable colour classifier: channel indices,
// threshold-register select codes, FSM states and named colour codes.
package color_pkg;

    // Channel index inside the 3-bit candidate / colour word.
    localparam int CH_R = 0;
    localparam int CH_G = 1;
    localparam int CH_B = 2;
    localparam int NUM_CH = 3;

    // thr_sel encodings for the run-time programmable registers.
    localparam logic [1:0] SEL_THR_R = 2'd0;
    localparam logic [1:0] SEL_THR_G = 2'd1;
    localparam logic [1:0] SEL_THR_B = 2'd2;
    localparam logic [1:0] SEL_HYST  = 2'd3;

    // Commit FSM states.
    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,  // nothing committed yet
        S_HOLD    = 2'd1,  // candidate agrees with the committed colour
        S_CONFIRM = 2'd2   // a different candidate is being confirmed
    } state_e;

    // Colour word, bit0 = R, bit1 = G, bit2 = B, active-high form.
    typedef logic [2:0] color_t;

    localparam color_t COLOR_BLACK   = 3'b000;
    localparam color_t COLOR_RED     = 3'b001;
    localparam color_t COLOR_GREEN   = 3'b010;
    localparam color_t COLOR_YELLOW  = 3'b011;
    localparam color_t COLOR_BLUE    = 3'b100;
    localparam color_t COLOR_MAGENTA = 3'b101;
    localparam color_t COLOR_CYAN    = 3'b110;
    localparam color_t COLOR_WHITE   = 3'b111;

    // Map an active-high colour onto the pin polarity of the LED driver.
    function automatic color_t apply_polarity(input color_t c, input bit active_low);
        return active_low ? ~c : c;
    endfunction

endpackage

// File: rtl/color_classifier_stable_hyst_cmp.sv
// One channel of the hysteresis comparator: builds a saturated upper and
// lower switching point around the threshold and keeps the channel flag.
module color_hyst_cmp #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_en,
    input  logic [DATA_W-1:0] value,
    input  logic [DATA_W-1:0] thr,
    input  logic [DATA_W-1:0] hyst,
    output logic              flag
);

    // Largest representable channel value, in the widened comparison domain.
    localparam logic [DATA_W:0] MAX_VAL = {1'b0, {DATA_W{1'b1}}};

    logic [DATA_W:0] sum_w;
    logic [DATA_W:0] diff_w;
    logic [DATA_W:0] upper_w;
    logic [DATA_W:0] lower_w;
    logic [DATA_W:0] value_w;
    logic            flag_d;
    logic            flag_q;

    // Switching points and next flag value; the flag holds inside the band.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        sum_w   = {1'b0, thr} + {1'b0, hyst};
        diff_w  = {1'b0, thr} - {1'b0, hyst};
        value_w = {1'b0, value};
        // The extra bit catches overflow of thr+hyst and the borrow of thr-hyst.
        upper_w = (sum_w > MAX_VAL) ? MAX_VAL : sum_w;
        lower_w = diff_w[DATA_W] ? '0 : diff_w;
        flag_d  = flag_q;
        if (sample_en) begin
            if (value_w > upper_w) begin
                flag_d = 1'b1;
            end else if (value_w < lower_w) begin
                flag_d = 1'b0;
            end
        end
    end

    // Flag register, updated only on accepted samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops see pre-edge values.
            flag_q <= flag_d;
        end
    end

    assign flag = flag_q;

endmodule

// File: rtl/color_classifier_stable.sv
// Stable RGB colour classifier: per-channel hysteresis against programmable
// thresholds, then a debounce FSM that commits a colour only after it has
// been seen on STABLE_CNT consecutive valid samples.
module color_classifier_stable #(
    parameter int DATA_W         = 16,
    parameter int STABLE_CNT     = 3,
    parameter int ACTIVE_LOW_OUT = 1,
    parameter int THR_R_DEF      = 50,
    parameter int THR_G_DEF      = 30,
    parameter int THR_B_DEF      = 30,
    parameter int HYST_DEF       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] red_norm,
    input  logic [DATA_W-1:0] green_norm,
    input  logic [DATA_W-1:0] blue_norm,
    input  logic              thr_wr_en,
    input  logic [1:0]        thr_sel,
    input  logic [DATA_W-1:0] thr_data,
    output logic [2:0]        color,
    output logic              color_valid,
    output logic              color_changed
);

    import color_pkg::*;

    // Run counter is just wide enough to hold STABLE_CNT and saturates there.
    localparam int                CNT_W    = $clog2(STABLE_CNT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STABLE_CNT);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam bit                ONE_SHOT = (STABLE_CNT == 1);
    localparam bit                OUT_LOW  = (ACTIVE_LOW_OUT != 0);

    // ------------------------------------------------------------------
    // Threshold / hysteresis registers
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] thr_d  [NUM_CH];
    logic [DATA_W-1:0] thr_q  [NUM_CH];
    logic [DATA_W-1:0] hyst_d;
    logic [DATA_W-1:0] hyst_q;

    // Register write decode; samples on the same edge still see the old values.
    always_comb begin
        thr_d  = thr_q;
        hyst_d = hyst_q;
        if (thr_wr_en) begin
            case (thr_sel)
                SEL_THR_R: thr_d[CH_R] = thr_data;
                SEL_THR_G: thr_d[CH_G] = thr_data;
                SEL_THR_B: thr_d[CH_B] = thr_data;
                SEL_HYST:  hyst_d      = thr_data;
                default:   hyst_d      = hyst_q;
            endcase
        end
    end

    // Configuration registers with their documented power-on defaults.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this small register file is reset because software relies on known defaults;
            //       a large data memory would normally be left unreset.
            thr_q[CH_R] <= DATA_W'(THR_R_DEF);
            thr_q[CH_G] <= DATA_W'(THR_G_DEF);
            thr_q[CH_B] <= DATA_W'(THR_B_DEF);
            hyst_q      <= DATA_W'(HYST_DEF);
        end else begin
            thr_q  <= thr_d;
            hyst_q <= hyst_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: per-channel hysteresis flags
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] chan_val [NUM_CH];
    color_t            cand;
    logic              cand_vld_d;
    logic              cand_vld_q;

    assign chan_val[CH_R] = red_norm;
    assign chan_val[CH_G] = green_norm;
    assign chan_val[CH_B] = blue_norm;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        color_hyst_cmp #(
            .DATA_W (DATA_W)
        ) u_cmp (
            .clk       (clk),
            .rst_n     (rst_n),
            .sample_en (in_valid),
            .value     (chan_val[c]),
            .thr       (thr_q[c]),
            .hyst      (hyst_q),
            .flag      (cand[c])
        );
    end

    assign cand_vld_d = in_valid;

    // Candidate-valid strobe follows the flags by the same single edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_vld_q <= 1'b0;
        end else begin
            cand_vld_q <= cand_vld_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: debounce / commit FSM
    // ------------------------------------------------------------------
    state_e           state_d,         state_q;
    color_t           committed_d,     committed_q;
    color_t           pending_d,       pending_q;
    logic [CNT_W-1:0] run_cnt_d,       run_cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             color_valid_d,   color_valid_q;
    logic             color_changed_d, color_changed_q;

    // Next-state logic; gap cycles (cand_vld_q=0) leave every register untouched.
    always_comb begin
        state_d         = state_q;
        committed_d     = committed_q;
        pending_d       = pending_q;
        run_cnt_d       = run_cnt_q;
        color_valid_d   = color_valid_q;
        color_changed_d = 1'b0;
        cnt_inc         = (run_cnt_q == CNT_MAX) ? run_cnt_q : run_cnt_q + CNT_ONE;

        if (cand_vld_q) begin
            case (state_q)
                S_EMPTY: begin
                    // A zero count means no run has started since reset.
                    if ((run_cnt_q != '0) && (cand == pending_q)) begin
                        run_cnt_d = cnt_inc;
                    end else begin
                        pending_d = cand;
                        run_cnt_d = CNT_ONE;
                    end
                    if (run_cnt_d == CNT_MAX) begin
                        committed_d     = pending_d;
                        color_valid_d   = 1'b1;
                        color_changed_d = 1'b1;
                        run_cnt_d       = '0;
                        state_d         = S_HOLD;
                    end
                end

                S_HOLD: begin
                    if (cand != committed_q) begin
                        if (ONE_SHOT) begin
                            committed_d     = cand;
                            color_changed_d = 1'b1;
                        end else begin
                            pending_d = cand;
                            run_cnt_d = CNT_ONE;
                            state_d   = S_CONFIRM;
                        end
                    end
                end

                S_CONFIRM: begin
                    if (cand == committed_q) begin
                        // Excursion ended before confirmation: drop it.
                        run_cnt_d = '0;
                        state_d   = S_HOLD;
                    end else if (cand == pending_q) begin
                        run_cnt_d = cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            committed_d     = pending_q;
                            color_changed_d = 1'b1;
                            run_cnt_d       = '0;
                            state_d         = S_HOLD;
                        end
                    end else begin
                        pending_d = cand;
                        run_cnt_d = CNT_ONE;
                    end
                end

                default: begin
                    state_d   = S_EMPTY;
                    run_cnt_d = '0;
                end
            endcase
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_EMPTY;
            committed_q     <= COLOR_BLACK;
            pending_q       <= COLOR_BLACK;
            run_cnt_q       <= '0;
            color_valid_q   <= 1'b0;
            color_changed_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            committed_q     <= committed_d;
            pending_q       <= pending_d;
            run_cnt_q       <= run_cnt_d;
            color_valid_q   <= color_valid_d;
            color_changed_q <= color_changed_d;
        end
    end

    assign color         = apply_polarity(committed_q, OUT_LOW);
    assign color_valid   = color_valid_q;
    assign color_changed = color_changed_q;

endmodule

// File: tb/tb_color_classifier_stable.sv
// Self-checking bench for color_classifier_stable with a window-based
// reference model: a colour is committed when the last STABLE_CNT valid
// candidates are identical and differ from the committed colour.
module tb_color_classifier_stable;

    localparam int DATA_W     = 16;
    localparam int STABLE_CNT = 3;
    localparam int MAX_VAL    = (1 << DATA_W) - 1;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic [DATA_W-1:0] red_norm;
    logic [DATA_W-1:0] green_norm;
    logic [DATA_W-1:0] blue_norm;
    logic              thr_wr_en;
    logic [1:0]        thr_sel;
    logic [DATA_W-1:0] thr_data;
    logic [2:0]        color;
    logic              color_valid;
    logic              color_changed;

    color_classifier_stable #(
        .DATA_W         (DATA_W),
        .STABLE_CNT     (STABLE_CNT),
        .ACTIVE_LOW_OUT (1),
        .THR_R_DEF      (50),
        .THR_G_DEF      (30),
        .THR_B_DEF      (30),
        .HYST_DEF       (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .red_norm      (red_norm),
        .green_norm    (green_norm),
        .blue_norm     (blue_norm),
        .thr_wr_en     (thr_wr_en),
        .thr_sel       (thr_sel),
        .thr_data      (thr_data),
        .color         (color),
        .color_valid   (color_valid),
        .color_changed (color_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    // ---------------- reference model ----------------
    int         m_thr [4];     // red, green, blue thresholds, hysteresis
    bit [2:0]   m_flags;       // per-channel presence, bit0 = R
    bit [2:0]   m_cand;        // candidate produced by the last valid sample
    bit         m_cand_vld;    // a sample was accepted on the previous edge
    bit [2:0]   m_hist [$];    // last STABLE_CNT valid candidates
    bit [2:0]   m_color;       // committed colour, active-high
    bit         m_valid;
    bit         m_changed;

    function automatic void model_reset();
        m_thr[0]   = 50;
        m_thr[1]   = 30;
        m_thr[2]   = 30;
        m_thr[3]   = 4;
        m_flags    = '0;
        m_cand     = '0;
        m_cand_vld = 1'b0;
        m_hist.delete();
        m_color    = '0;
        m_valid    = 1'b0;
        m_changed  = 1'b0;
    endfunction

    function automatic void model_edge(input bit v, input int r, input int g, input int b,
                                       input bit wr, input int sel, input int data);
        int  vals [3];
        int  upper;
        int  lower;
        bit  all_eq;
        m_changed = 1'b0;
        // Decision on the candidate produced one edge earlier.
        if (m_cand_vld) begin
            m_hist.push_back(m_cand);
            if (m_hist.size() > STABLE_CNT) void'(m_hist.pop_front());
            if (m_hist.size() == STABLE_CNT) begin
                all_eq = 1'b1;
                foreach (m_hist[i]) if (m_hist[i] != m_hist[0]) all_eq = 1'b0;
                if (all_eq && (!m_valid || m_hist[0] != m_color)) begin
                    m_color   = m_hist[0];
                    m_valid   = 1'b1;
                    m_changed = 1'b1;
                end
            end
        end
        // New sample against the thresholds in force before this edge.
        if (v) begin
            vals[0] = r;
            vals[1] = g;
            vals[2] = b;
            for (int c = 0; c < 3; c++) begin
                upper = m_thr[c] + m_thr[3];
                if (upper > MAX_VAL) upper = MAX_VAL;
                lower = m_thr[c] - m_thr[3];
                if (lower < 0) lower = 0;
                if (vals[c] > upper) m_flags[c] = 1'b1;
                else if (vals[c] < lower) m_flags[c] = 1'b0;
            end
            m_cand = m_flags;
        end
        m_cand_vld = v;
        if (wr) m_thr[sel] = data;
    endfunction

    // ---------------- stimulus primitives ----------------
    // Called at posedge+1; returns at the next posedge+1 with the model advanced.
    task automatic cycle(input bit v, input int r, input int g, input int b,
                         input bit wr, input int sel, input int data);
        in_valid   = v;
        red_norm   = DATA_W'(r);
        green_norm = DATA_W'(g);
        blue_norm  = DATA_W'(b);
        thr_wr_en  = wr;
        thr_sel    = 2'(sel);
        thr_data   = DATA_W'(data);
        @(posedge clk);
        model_edge(v, r, g, b, wr, sel, data);
        #1;
        in_valid  = 1'b0;
        thr_wr_en = 1'b0;
    endtask

    // n back-to-back samples plus one flush cycle, compared with the model each cycle.
    task automatic run_seq(input string name, input int r, input int g, input int b,
                           input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i <= n; i++) begin
            if (i < n) cycle(1'b1, r, g, b, 1'b0, 0, 0);
            else       cycle(1'b0, 0, 0, 0, 1'b0, 0, 0);
            checks++;
            if ({color, color_valid, color_changed} !== {~m_color, m_valid, m_changed}) begin
                failures++;
                $display("FAIL %s cyc=%0d got color=%b valid=%b chg=%b exp color=%b valid=%b chg=%b",
                         name, i, color, color_valid, color_changed, ~m_color, m_valid, m_changed);
            end
            pulses += int'(color_changed);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        checks++;
        if ({color, color_valid, color_changed} !== {3'b111, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_hold got color=%b valid=%b chg=%b exp 111/0/0",
                     color, color_valid, color_changed);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b0, 0, 0, 0, 1'b0, 0, 0);
        checks++;
        if ({color, color_valid, color_changed} !== {3'b111, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_release got color=%b valid=%b chg=%b exp 111/0/0",
                     color, color_valid, color_changed);
        end
    endtask

    task automatic test_commit();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (j == 0) cycle(1'b1, 100, 0, 0, 1'b0, 0, 0);
                else        cycle(1'b0, 0, 0, 0, 1'b0, 0, 0);
                checks++;
                if ({color, color_valid, color_changed} !== {~m_color, m_valid, m_changed}) begin
                    failures++;
                    $display("FAIL commit s=%0d c=%0d got color=%b valid=%b chg=%b exp color=%b valid=%b chg=%b",
                             i, j, color, color_valid, color_changed, ~m_color, m_valid, m_changed);
                end
                pulses += int'(color_changed);
            end
        end
        checks++;
        if ({color, color_valid} !== {3'b110, 1'b1} || pulses != 1) begin
            failures++;
            $display("FAIL commit_final got color=%b valid=%b pulses=%0d exp 110/1 pulses=1",
                     color, color_valid, pulses);
        end
    endtask

    task automatic test_hysteresis();
        int p1, p2, p3;
        run_seq("hyst_in_band", 50, 0, 0, 1, p1);
        run_seq("hyst_in_band", 47, 0, 0, 5, p2);
        checks++;
        if (color !== 3'b110 || (p1 + p2) != 0) begin
            failures++;
            $display("FAIL hyst_hold got color=%b pulses=%0d exp 110 pulses=0", color, p1 + p2);
        end
        run_seq("hyst_below", 45, 0, 0, 3, p3);
        checks++;
        if (color !== 3'b111 || p3 != 1) begin
            failures++;
            $display("FAIL hyst_clear got color=%b pulses=%0d exp 111 pulses=1", color, p3);
        end
        run_seq("hyst_upper_edge", 54, 0, 0, 3, p1);
        checks++;
        if (color !== 3'b111 || p1 != 0) begin
            failures++;
            $display("FAIL hyst_at_upper got color=%b pulses=%0d exp 111 pulses=0", color, p1);
        end
        run_seq("hyst_above", 55, 0, 0, 3, p1);
        checks++;
        if (color !== 3'b110 || p1 != 1) begin
            failures++;
            $display("FAIL hyst_set got color=%b pulses=%0d exp 110 pulses=1", color, p1);
        end
    endtask

    task automatic test_glitch();
        int p1, p2, p3;
        run_seq("glitch_steady", 100, 0, 0, 3, p1);
        run_seq("glitch_green", 0, 100, 0, 2, p2);
        run_seq("glitch_back", 100, 0, 0, 3, p3);
        checks++;
        if (color !== 3'b110 || (p1 + p2 + p3) != 0) begin
            failures++;
            $display("FAIL glitch got color=%b pulses=%0d exp 110 pulses=0", color, p1 + p2 + p3);
        end
    endtask

    task automatic test_runtime_thr();
        int p1, p2;
        // Sample and write on the same edge: this sample still uses threshold 50.
        cycle(1'b1, 100, 0, 0, 1'b1, 0, 200);
        run_seq("thr_after_wr", 100, 0, 0, 2, p1);
        checks++;
        if (color !== 3'b110 || p1 != 0) begin
            failures++;
            $display("FAIL thr_same_edge got color=%b pulses=%0d exp 110 pulses=0", color, p1);
        end
        run_seq("thr_third", 100, 0, 0, 1, p2);
        checks++;
        if (color !== 3'b111 || p2 != 1) begin
            failures++;
            $display("FAIL thr_new_value got color=%b pulses=%0d exp 111 pulses=1", color, p2);
        end
        cycle(1'b0, 0, 0, 0, 1'b1, 0, 50);
    endtask

    task automatic test_reset_mid_confirm();
        int p1, p2;
        run_seq("mid_pre", 100, 0, 0, 2, p1);
        rst_n = 1'b0;
        #2;
        model_reset();
        checks++;
        if ({color, color_valid, color_changed} !== {3'b111, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL mid_reset got color=%b valid=%b chg=%b exp 111/0/0",
                     color, color_valid, color_changed);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_seq("mid_after", 100, 0, 0, 2, p1);
        checks++;
        if (color_valid !== 1'b0 || p1 != 0) begin
            failures++;
            $display("FAIL mid_two_samples got valid=%b pulses=%0d exp 0 pulses=0", color_valid, p1);
        end
        run_seq("mid_third", 100, 0, 0, 1, p2);
        checks++;
        if ({color, color_valid} !== {3'b110, 1'b1} || p2 != 1) begin
            failures++;
            $display("FAIL mid_recommit got color=%b valid=%b pulses=%0d exp 110/1 pulses=1",
                     color, color_valid, p2);
        end
    endtask

    task automatic test_random();
        bit v, wr;
        int sel, data;
        for (int i = 0; i < 600; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            wr = ($urandom_range(0, 24) == 0);
            sel = $urandom_range(0, 3);
            data = (sel == 3) ? $urandom_range(0, 8) : $urandom_range(10, 90);
            // Stick to a few colours for a while so commits actually happen.
            cycle(v, (i / 7) % 2 == 0 ? $urandom_range(0, 110) : $urandom_range(40, 60),
                  $urandom_range(0, 70), $urandom_range(0, 70), wr, sel, data);
            checks++;
            if ({color, color_valid, color_changed} !== {~m_color, m_valid, m_changed}) begin
                failures++;
                $display("FAIL random cyc=%0d got color=%b valid=%b chg=%b exp color=%b valid=%b chg=%b",
                         i, color, color_valid, color_changed, ~m_color, m_valid, m_changed);
            end
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        red_norm   = '0;
        green_norm = '0;
        blue_norm  = '0;
        thr_wr_en  = 1'b0;
        thr_sel    = '0;
        thr_data   = '0;
        test_reset();
        test_commit();
        test_hysteresis();
        test_glitch();
        test_runtime_thr();
        test_reset_mid_confirm();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
